// File: rtl/axi4_dma_pkg.sv
// Shared types for the DMA register-access path: arbiter state encoding and
// AXI read response codes.
package axi4_dma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    HOLD    = 3'b010,
    RELEASE = 3'b100
  } arb_state_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } read_response_e;

endpackage

// File: rtl/axi4_regfile_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester set after 'last', with
// wrap-around, found by masking the lower copy of a doubled request vector.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 any,
  output logic [$clog2(N)-1:0] winner,
  output logic [N-1:0]         onehot
);

  localparam int IW = $clog2(N);

  logic [2*N-1:0] masked;

  always_comb begin
    masked = {req, req};
    for (int i = 0; i < 2 * N; i++) begin
      if (i <= int'(last)) masked[i] = 1'b0;
    end
    // Descending scan so the lowest surviving bit is the one that sticks.
    winner = '0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (masked[i]) winner = IW'(i % N);
    end
    onehot         = '0;
    onehot[winner] = 1'b1;
    any            = |req;
  end

endmodule

// File: rtl/axi4_regfile_read_arbiter.sv
// Round-robin sharing of the single register-file read port among NUM_REQ
// requesters; address held for HOLD_CYCLES, then data returned with a valid pulse.
module axi4_regfile_read_arbiter
  import axi4_dma_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DEPTH       = 8,
  parameter int DATA_SIZE   = 32,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_clk_ni,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ*$clog2(DEPTH)-1:0]   req_address_i,
  output logic [NUM_REQ-1:0]                 grant_o,
  output logic [DATA_SIZE-1:0]               data_o,
  output logic [NUM_REQ-1:0]                 data_valid_o,
  output logic [1:0]                         resp_o,
  output logic [$clog2(DEPTH)-1:0]           register_address_o,
  input  logic [DATA_SIZE-1:0]               register_data_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  arb_state_e state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        last_q, last_d;
  logic [NUM_REQ-1:0]   grant_d, valid_d;
  logic [DATA_SIZE-1:0] data_d;
  logic [1:0]           resp_d;
  logic [AW-1:0]        addr_d;

  logic                 pick_any;
  logic [IW-1:0]        pick_win;
  logic [NUM_REQ-1:0]   pick_onehot;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req    (req_i),
    .last   (last_q),
    .any    (pick_any),
    .winner (pick_win),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_o;
    addr_d  = register_address_o;
    data_d  = data_o;
    resp_d  = resp_o;
    valid_d = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_onehot;
          addr_d  = req_address_i[pick_win*AW +: AW];
          last_d  = pick_win;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // Out-of-range reads still capture whatever the port returns.
          data_d  = register_data_i;
          resp_d  = (int'(register_address_o) >= DEPTH) ? DECERR : OKAY;
          valid_d = grant_o;
          grant_d = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_clk_ni) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      last_q             <= LAST_RST;
      grant_o            <= '0;
      register_address_o <= '0;
      data_o             <= '0;
      resp_o             <= '0;
      data_valid_o       <= '0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      last_q             <= last_d;
      grant_o            <= grant_d;
      register_address_o <= addr_d;
      data_o             <= data_d;
      resp_o             <= resp_d;
      data_valid_o       <= valid_d;
    end
  end

  a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_clk_ni)
    $onehot0(grant_o));
  a_valid_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_clk_ni)
    $onehot0(data_valid_o));
  a_addr_stable : assert property (@(posedge clk_i) disable iff (!rst_clk_ni)
    (state_q == HOLD && $past(state_q) == HOLD) |-> $stable(register_address_o));

endmodule

// File: tb/tb_axi4_regfile_read_arbiter.sv
// Directed bench: three arbiter instances (default, 3 requesters, depth 6)
// each with a simple combinational register-file model.
module tb_axi4_regfile_read_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  logic        rstA_n, rstB_n;

  logic [1:0]  reqA, grantA, validA, respA;
  logic [5:0]  addrA;
  logic [31:0] dataA, rdataA;
  logic [2:0]  raddrA;

  logic [2:0]  reqB, grantB, validB;
  logic [1:0]  respB;
  logic [8:0]  addrB;
  logic [31:0] dataB, rdataB;
  logic [2:0]  raddrB;

  logic [1:0]  reqC, grantC, validC, respC;
  logic [5:0]  addrC;
  logic [31:0] dataC, rdataC;
  logic [2:0]  raddrC;

  assign rdataA = (raddrA == 3'd5) ? 32'hDEADBEEF : (32'hA000_0000 | 32'(raddrA));
  assign rdataB = 32'hB000_0000 | 32'(raddrB);
  assign rdataC = 32'hC000_0000 | 32'(raddrC);

  axi4_regfile_read_arbiter #(.NUM_REQ(2), .DEPTH(8), .DATA_SIZE(32), .HOLD_CYCLES(4)) dutA (
    .clk_i(clk), .rst_clk_ni(rstA_n), .req_i(reqA), .req_address_i(addrA),
    .grant_o(grantA), .data_o(dataA), .data_valid_o(validA), .resp_o(respA),
    .register_address_o(raddrA), .register_data_i(rdataA)
  );

  axi4_regfile_read_arbiter #(.NUM_REQ(3), .DEPTH(8), .DATA_SIZE(32), .HOLD_CYCLES(4)) dutB (
    .clk_i(clk), .rst_clk_ni(rstB_n), .req_i(reqB), .req_address_i(addrB),
    .grant_o(grantB), .data_o(dataB), .data_valid_o(validB), .resp_o(respB),
    .register_address_o(raddrB), .register_data_i(rdataB)
  );

  axi4_regfile_read_arbiter #(.NUM_REQ(2), .DEPTH(6), .DATA_SIZE(32), .HOLD_CYCLES(4)) dutC (
    .clk_i(clk), .rst_clk_ni(rstB_n), .req_i(reqC), .req_address_i(addrC),
    .grant_o(grantC), .data_o(dataC), .data_valid_o(validC), .resp_o(respC),
    .register_address_o(raddrC), .register_data_i(rdataC)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    else passCount++;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [5:0] addr);
    reqA  = req;
    addrA = addr;
  endtask

  initial begin
    logic [1:0]  expGrant, expValid;
    logic [31:0] expData;

    rstA_n = 1'b0; rstB_n = 1'b0;
    reqA = '0; addrA = '0; reqB = '0; addrB = '0; reqC = '0; addrC = '0;
    stepCycle();
    stepCycle();
    checkOutput("reset grant", 64'(grantA), 64'h0);
    checkOutput("reset valid", 64'(validA), 64'h0);
    checkOutput("reset data", 64'(dataA), 64'h0);
    checkOutput("reset resp", 64'(respA), 64'h0);
    checkOutput("reset raddr", 64'(raddrA), 64'h0);
    rstA_n = 1'b1; rstB_n = 1'b1;
    stepCycle();
    checkOutput("idle grant", 64'(grantA), 64'h0);

    $display("[TB] single read");
    applyStimulus(2'b01, {3'd0, 3'd5});
    stepCycle();
    checkOutput("single grant e0", 64'(grantA), 64'h1);
    checkOutput("single raddr e0", 64'(raddrA), 64'h5);
    checkOutput("single valid e0", 64'(validA), 64'h0);
    for (int k = 1; k < 4; k++) begin
      stepCycle();
      checkOutput($sformatf("single grant e%0d", k), 64'(grantA), 64'h1);
      checkOutput($sformatf("single raddr e%0d", k), 64'(raddrA), 64'h5);
      checkOutput($sformatf("single valid e%0d", k), 64'(validA), 64'h0);
    end
    stepCycle();
    checkOutput("single valid e4", 64'(validA), 64'h1);
    checkOutput("single data e4", 64'(dataA), 64'hDEADBEEF);
    checkOutput("single resp e4", 64'(respA), 64'h0);
    checkOutput("single grant e4", 64'(grantA), 64'h0);
    applyStimulus(2'b00, {3'd0, 3'd5});
    stepCycle();
    checkOutput("single valid e5", 64'(validA), 64'h0);
    checkOutput("single data kept", 64'(dataA), 64'hDEADBEEF);
    checkOutput("single raddr kept", 64'(raddrA), 64'h5);
    stepCycle();
    checkOutput("single no regrant", 64'(grantA), 64'h0);

    $display("[TB] early drop");
    applyStimulus(2'b10, {3'd2, 3'd0});
    stepCycle();
    checkOutput("drop grant e0", 64'(grantA), 64'h2);
    checkOutput("drop raddr e0", 64'(raddrA), 64'h2);
    stepCycle();
    applyStimulus(2'b00, {3'd2, 3'd0});
    stepCycle();
    stepCycle();
    checkOutput("drop grant e3", 64'(grantA), 64'h2);
    stepCycle();
    checkOutput("drop valid e4", 64'(validA), 64'h2);
    checkOutput("drop data e4", 64'(dataA), 64'hA000_0002);
    stepCycle();
    checkOutput("drop valid e5", 64'(validA), 64'h0);
    stepCycle();
    stepCycle();
    checkOutput("drop no regrant", 64'(grantA), 64'h0);

    $display("[TB] contention");
    applyStimulus(2'b11, {3'd4, 3'd1});
    for (int e = 0; e < 24; e++) begin
      stepCycle();
      expGrant = ((e / 6) % 2 == 0) ? 2'b01 : 2'b10;
      expData  = ((e / 6) % 2 == 0) ? 32'hA000_0001 : 32'hA000_0004;
      expValid = (e % 6 == 4) ? expGrant : 2'b00;
      if (e % 6 >= 4) expGrant = 2'b00;
      checkOutput($sformatf("contention grant e%0d", e), 64'(grantA), 64'(expGrant));
      checkOutput($sformatf("contention valid e%0d", e), 64'(validA), 64'(expValid));
      if (e % 6 == 4) checkOutput($sformatf("contention data e%0d", e), 64'(dataA), 64'(expData));
    end
    applyStimulus(2'b00, {3'd4, 3'd1});

    $display("[TB] reset mid-hold");
    applyStimulus(2'b01, {3'd0, 3'd3});
    stepCycle();
    checkOutput("rst grant e0", 64'(grantA), 64'h1);
    stepCycle();
    stepCycle();
    rstA_n = 1'b0;
    applyStimulus(2'b11, {3'd0, 3'd3});
    stepCycle();
    checkOutput("rst grant", 64'(grantA), 64'h0);
    checkOutput("rst valid", 64'(validA), 64'h0);
    checkOutput("rst data", 64'(dataA), 64'h0);
    checkOutput("rst resp", 64'(respA), 64'h0);
    checkOutput("rst raddr", 64'(raddrA), 64'h0);
    rstA_n = 1'b1;
    stepCycle();
    checkOutput("post-rst grant", 64'(grantA), 64'h1);
    checkOutput("post-rst raddr", 64'(raddrA), 64'h3);
    stepCycle();
    checkOutput("post-rst no valid", 64'(validA), 64'h0);

    $display("[TB] fairness, three requesters");
    reqB  = 3'b101;
    addrB = {3'd3, 3'd2, 3'd1};
    for (int e = 0; e <= 18; e++) begin
      stepCycle();
      if (e == 0) begin
        checkOutput("fair grant 1st", 64'(grantB), 64'h1);
        reqB = 3'b111;
      end
      if (e == 4) checkOutput("fair valid 1st", 64'(validB), 64'h1);
      if (e == 6) checkOutput("fair grant 2nd", 64'(grantB), 64'h2);
      if (e == 10) begin
        checkOutput("fair valid 2nd", 64'(validB), 64'h2);
        checkOutput("fair data 2nd", 64'(dataB), 64'hB000_0002);
        reqB = 3'b101;
      end
      if (e == 12) checkOutput("fair grant 3rd", 64'(grantB), 64'h4);
      if (e == 18) checkOutput("fair grant 4th", 64'(grantB), 64'h1);
    end
    reqB = 3'b000;

    $display("[TB] decode error, depth 6");
    reqC  = 2'b01;
    addrC = {3'd0, 3'd7};
    stepCycle();
    checkOutput("decerr grant", 64'(grantC), 64'h1);
    checkOutput("decerr raddr", 64'(raddrC), 64'h7);
    for (int k = 1; k < 4; k++) stepCycle();
    stepCycle();
    checkOutput("decerr valid", 64'(validC), 64'h1);
    checkOutput("decerr resp", 64'(respC), 64'h3);
    checkOutput("decerr data", 64'(dataC), 64'hC000_0007);
    reqC = 2'b00;
    stepCycle();
    stepCycle();
    reqC  = 2'b10;
    addrC = {3'd3, 3'd0};
    stepCycle();
    checkOutput("okay grant", 64'(grantC), 64'h2);
    for (int k = 1; k < 4; k++) stepCycle();
    stepCycle();
    checkOutput("okay valid", 64'(validC), 64'h2);
    checkOutput("okay resp", 64'(respC), 64'h0);
    checkOutput("okay data", 64'(dataC), 64'hC000_0003);
    reqC = 2'b00;
    stepCycle();
    stepCycle();
    reqC  = 2'b01;
    addrC = {3'd0, 3'd6};
    for (int k = 0; k < 4; k++) stepCycle();
    stepCycle();
    checkOutput("edge decerr valid", 64'(validC), 64'h1);
    checkOutput("edge decerr resp", 64'(respC), 64'h3);
    reqC = 2'b00;
    stepCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
